ascon_serial_loader: RTL and testbench
======================================

Name: ascon_serial_loader

Overview:
- Hardware transmitter for the Ascon core's bit-serial load interface.
- Snapshots parallel key, nonce, associated data and plaintext, then shifts them MSB-first onto the core's 5-bit share inputs, one bit per cycle.
- Drives the masking-randomness buses from an internal LFSR, pulses encryption start, then waits for the core's ready.
- Replaces the simulation-only writer so the core can be driven by an SoC register front-end.

Parameters:
- K, 128, key width in bits.
- L, 40, associated-data width in bits.
- Y, 96, plaintext width in bits.
- START_CYC, 3, cycles encryption start is held high.
- SEED, 64'hACE1_0000_0000_0001, LFSR reset value; must be nonzero.
- MAX (localparam), max(K, L, Y, 128), number of load cycles.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request a load+encrypt sequence.
- abort_i  in  1  synchronous abort back to IDLE.
- key_i  in  K  key.
- nonce_i  in  128  nonce.
- ad_i  in  L  associated data.
- pt_i  in  Y  plaintext.
- enc_ready_i  in  1  core encryption-ready flag.
- key_o  out  5  [0] = data bit, [4:1] = mask bits.
- nonce_o  out  5  same layout as key_o.
- ad_o  out  5  same layout as key_o.
- pt_o  out  5  same layout as key_o.
- r_64_o  out  14  core randomness.
- r_128_o  out  3  core randomness.
- r_pt_o  out  3  core randomness.
- enc_start_o  out  1  core encryption start.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse when core signals ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; all outputs 0.
  - Bit counter 0; LFSR = SEED; snapshot registers 0.
- All outputs are registered.
- States: IDLE, LOAD, START, WAIT.
- IDLE:
  - start_i=1 at an edge: snapshot all four data inputs, counter=0, go to LOAD.
  - start_i is ignored in every other state; no queuing.
- LOAD (exactly MAX cycles; counter c = 0..MAX-1):
  - Outputs during cycle c: key_o[0]=key[K-1-c], nonce_o[0]=nonce[127-c], ad_o[0]=ad[L-1-c], pt_o[0]=pt[Y-1-c].
  - Any index below 0 (c ≥ field width) drives 0.
  - First data bit is visible the cycle after start is accepted.
  - When c = MAX-1, go to START.
- START:
  - enc_start_o=1 for START_CYC cycles; data bits 0.
  - Then enc_start_o=0, go to WAIT.
- WAIT:
  - enc_ready_i sampled 1: done_o=1 for one cycle, go to IDLE.
  - No timeout.
- abort_i=1 in any state:
  - Next state IDLE; data, mask and start outputs 0 next cycle; done_o not asserted.
  - abort_i has priority over start_i and enc_ready_i in the same cycle.
- enc_ready_i=1 outside WAIT: ignored.
- Back-to-back operation: start_i=1 in the same cycle done_o=1 is ignored; it is accepted in the next IDLE cycle.
- LFSR:
  - 64-bit Fibonacci, shift left; feedback = s[63]^s[62]^s[60]^s[59].
  - Advances every cycle in LOAD and START; holds in IDLE and WAIT.
- Randomness mapping from LFSR state bits, in order {r_128_o, r_pt_o, r_64_o, key_o[4:1], ad_o[4:1], pt_o[4:1], nonce_o[4:1]} = s[35:0].
- Randomness outputs are 0 in IDLE and WAIT.
- Reset mid-operation: immediate return to reset values; LFSR reseeded.

Optional Feature:
- Macro: ASCON_LOADER_MASK_EN.
- Defined: mask and randomness outputs come from the LFSR as specified above.
- Undefined: the LFSR is not instantiated; all mask bits and r_* outputs are constant 0. This gives a deterministic unmasked load for debug and equivalence checking. Data bits and timing are unchanged.

Test Plan:
- Basic load: rst released; key=5362006eff0b33bc8bb9950abdb242fc, nonce=1ccfafbc6dc738283ca9fe21ce0fccaa, ad=4153434f4e, pt=48656c6c6f20576f726c6421; start_i pulse.
  - c=0: data bits key/nonce/ad/pt = 0/0/0/0.
  - c=1: data bits = 1/0/1/1.
  - c≥40: ad_o[0]=0; c≥96: pt_o[0]=0.
  - busy_o high for the whole sequence.
- Start and completion: after 128 LOAD cycles, enc_start_o is high exactly 3 cycles. Assert enc_ready_i 10 cycles later → done_o pulses once, then busy_o=0.
- Busy and ready filtering: start_i held high throughout, and enc_ready_i pulsed during LOAD. LOAD is not restarted; no done_o; counter reaches 127 normally.
- Abort: abort_i at c=50 → IDLE next cycle; all outputs 0. A new start reloads from c=0 with fresh snapshot data.
- Mid-operation reset: rst=0 at c=70 → outputs 0 immediately, without waiting for a clock edge. After release and start, the LFSR output sequence repeats the first run's.
- Macro off: rebuild without ASCON_LOADER_MASK_EN and repeat the basic load. All mask and r_* bits are 0 every cycle; data bits are identical to the first run.

Source files
------------

// File: rtl/ascon_serial_loader.sv
// ascon_serial_loader: bit-serial transmitter for the Ascon core load interface.
// Snapshots key/nonce/AD/plaintext, shifts them MSB-first one bit per cycle,
// pulses encryption start, then waits for the core's ready flag.
// Optional feature macro: ASCON_LOADER_MASK_EN (LFSR-driven masks/randomness).
// With the macro undefined, all mask and r_* outputs are tied to 0.
module ascon_serial_loader #(
   parameter int          K         = 128,
   parameter int          L         = 40,
   parameter int          Y         = 96,
   parameter int          START_CYC = 3,
   parameter logic [63:0] SEED      = 64'hACE1_0000_0000_0001
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   input  logic           abort_i,
   input  logic [K-1:0]   key_i,
   input  logic [127:0]   nonce_i,
   input  logic [L-1:0]   ad_i,
   input  logic [Y-1:0]   pt_i,
   input  logic           enc_ready_i,
   output logic [4:0]     key_o,
   output logic [4:0]     nonce_o,
   output logic [4:0]     ad_o,
   output logic [4:0]     pt_o,
   output logic [13:0]    r_64_o,
   output logic [2:0]     r_128_o,
   output logic [2:0]     r_pt_o,
   output logic           enc_start_o,
   output logic           busy_o,
   output logic           done_o
);

   localparam int MAX_KL  = (K > L) ? K : L;
   localparam int MAX_KLY = (MAX_KL > Y) ? MAX_KL : Y;
   localparam int MAX     = (MAX_KLY > 128) ? MAX_KLY : 128;
   localparam int CNT_LIM = (MAX > START_CYC) ? MAX : START_CYC;
   localparam int CNT_W   = $clog2(CNT_LIM + 1);

   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(MAX - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_START = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   if (SEED == 64'd0) begin : g_seed_check
      $error("ascon_serial_loader: SEED must be nonzero");
   end
   if (START_CYC < 1) begin : g_start_check
      $error("ascon_serial_loader: START_CYC must be at least 1");
   end

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [K-1:0]     key_sh_q, key_sh_d;
   logic [127:0]     nonce_sh_q, nonce_sh_d;
   logic [L-1:0]     ad_sh_q, ad_sh_d;
   logic [Y-1:0]     pt_sh_q, pt_sh_d;
   logic [3:0]       data_q, data_d;     // {key, nonce, ad, pt} data bits
   logic [35:0]      rnd_q, rnd_d;       // mask and randomness bits
   logic             enc_start_q, enc_start_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Sequencer: state, counter and snapshot shift registers for the next cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      key_sh_d   = key_sh_q;
      nonce_sh_d = nonce_sh_q;
      ad_sh_d    = ad_sh_q;
      pt_sh_d    = pt_sh_q;
      done_d     = 1'b0;
      if (abort_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // A start coinciding with the done pulse is dropped, not queued.
               if (start_i && !done_q) begin
                  state_d    = S_LOAD;
                  cnt_d      = '0;
                  key_sh_d   = key_i;
                  nonce_sh_d = nonce_i;
                  ad_sh_d    = ad_i;
                  pt_sh_d    = pt_i;
               end
            end
            S_LOAD: begin
               // Shifting in zeros makes exhausted short fields read as 0.
               key_sh_d   = {key_sh_q[K-2:0], 1'b0};
               nonce_sh_d = {nonce_sh_q[126:0], 1'b0};
               ad_sh_d    = {ad_sh_q[L-2:0], 1'b0};
               pt_sh_d    = {pt_sh_q[Y-2:0], 1'b0};
               if (cnt_q == LOAD_LAST) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_START: begin
               if (cnt_q == START_LAST) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_WAIT: begin
               if (enc_ready_i) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Registered outputs derived from the next-cycle state so they line up with it.
   always_comb begin
      data_d      = '0;
      enc_start_d = (state_d == S_START);
      busy_d      = (state_d != S_IDLE);
      if (state_d == S_LOAD) begin
         data_d = {key_sh_d[K-1], nonce_sh_d[127], ad_sh_d[L-1], pt_sh_d[Y-1]};
      end
   end

`ifdef ASCON_LOADER_MASK_EN
   logic [63:0] lfsr_q, lfsr_d;

   // LFSR advances only while loading or starting; exposed bits are 0 otherwise.
   always_comb begin
      lfsr_d = lfsr_q;
      rnd_d  = '0;
      if (state_q == S_LOAD || state_q == S_START) begin
         lfsr_d = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
      end
      if (state_d == S_LOAD || state_d == S_START) begin
         rnd_d = lfsr_d[35:0];
      end
   end

   // LFSR state register, reseeded on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   // Unmasked debug build: no randomness source, masks held at 0.
   always_comb begin
      rnd_d = '0;
   end
`endif

   // State, snapshot and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         key_sh_q    <= '0;
         nonce_sh_q  <= '0;
         ad_sh_q     <= '0;
         pt_sh_q     <= '0;
         data_q      <= '0;
         rnd_q       <= '0;
         enc_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_sh_q    <= key_sh_d;
         nonce_sh_q  <= nonce_sh_d;
         ad_sh_q     <= ad_sh_d;
         pt_sh_q     <= pt_sh_d;
         data_q      <= data_d;
         rnd_q       <= rnd_d;
         enc_start_q <= enc_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign key_o       = {rnd_q[15:12], data_q[3]};
   assign ad_o        = {rnd_q[11:8],  data_q[1]};
   assign pt_o        = {rnd_q[7:4],   data_q[0]};
   assign nonce_o     = {rnd_q[3:0],   data_q[2]};
   assign r_64_o      = rnd_q[29:16];
   assign r_pt_o      = rnd_q[32:30];
   assign r_128_o     = rnd_q[35:33];
   assign enc_start_o = enc_start_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_ascon_serial_loader.sv
// Testbench for ascon_serial_loader: transaction-level reference model feeding a
// scoreboard queue; a negedge monitor compares every cycle's full output vector.
module tb_ascon_serial_loader;

   localparam int K         = 128;
   localparam int L         = 40;
   localparam int Y         = 96;
   localparam int START_CYC = 3;
   localparam logic [63:0] SEED = 64'hACE1_0000_0000_0001;
   localparam int MAX       = 128;

   typedef struct packed {
      logic [4:0]  key;
      logic [4:0]  nonce;
      logic [4:0]  ad;
      logic [4:0]  pt;
      logic [13:0] r64;
      logic [2:0]  r128;
      logic [2:0]  rpt;
      logic        es;
      logic        busy;
      logic        done;
   } outv_t;

   typedef struct {
      int    cyc;
      outv_t v;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start_i = 1'b0, abort_i = 1'b0, enc_ready_i = 1'b0;
   logic [K-1:0]   key_i = '0;
   logic [127:0]   nonce_i = '0;
   logic [L-1:0]   ad_i = '0;
   logic [Y-1:0]   pt_i = '0;
   logic [4:0]     key_o, nonce_o, ad_o, pt_o;
   logic [13:0]    r_64_o;
   logic [2:0]     r_128_o, r_pt_o;
   logic           enc_start_o, busy_o, done_o;
   outv_t          act_v;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   // reference model state (transaction position, not RTL encoding)
   bit           m_act, m_wait, m_done;
   int           m_pos;
   logic [63:0]  m_lfsr;
   logic [K-1:0] mk;
   logic [127:0] mn;
   logic [L-1:0] ma;
   logic [Y-1:0] mp;

   ascon_serial_loader #(.K(K), .L(L), .Y(Y), .START_CYC(START_CYC), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
      .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .pt_i(pt_i),
      .enc_ready_i(enc_ready_i),
      .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o), .pt_o(pt_o),
      .r_64_o(r_64_o), .r_128_o(r_128_o), .r_pt_o(r_pt_o),
      .enc_start_o(enc_start_o), .busy_o(busy_o), .done_o(done_o)
   );

   assign act_v = {key_o, nonce_o, ad_o, pt_o, r_64_o, r_128_o, r_pt_o,
                   enc_start_o, busy_o, done_o};

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic compare(input string name, input outv_t act, input outv_t want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
      end
   endtask

   function automatic logic [63:0] lfsr_next(input logic [63:0] s);
      return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      m_act = 0; m_wait = 0; m_done = 0; m_pos = 0;
      m_lfsr = SEED;
      mk = '0; mn = '0; ma = '0; mp = '0;
   endtask

   // advance the model by one clock edge given the inputs presented at that edge
   task automatic model_step(input bit st, input bit ab, input bit rdy);
      bit prev_done;
      if (m_act && !m_wait) m_lfsr = lfsr_next(m_lfsr);
      prev_done = m_done;
      m_done = 0;
      if (ab) begin
         m_act = 0; m_wait = 0;
      end else if (!m_act) begin
         if (st && !prev_done) begin
            m_act = 1; m_wait = 0; m_pos = 0;
            mk = key_i; mn = nonce_i; ma = ad_i; mp = pt_i;
         end
      end else if (m_wait) begin
         if (rdy) begin
            m_act = 0; m_wait = 0; m_done = 1;
         end
      end else begin
         m_pos++;
         if (m_pos == MAX + START_CYC) m_wait = 1;
      end
   endtask

   function automatic outv_t model_out();
      outv_t v;
      bit ld, st;
      v  = '0;
      ld = m_act && !m_wait && (m_pos < MAX);
      st = m_act && !m_wait && (m_pos >= MAX);
      if (ld) begin
         v.key[0]   = (m_pos < K)   ? mk[K-1-m_pos]   : 1'b0;
         v.nonce[0] = (m_pos < 128) ? mn[127-m_pos]   : 1'b0;
         v.ad[0]    = (m_pos < L)   ? ma[L-1-m_pos]   : 1'b0;
         v.pt[0]    = (m_pos < Y)   ? mp[Y-1-m_pos]   : 1'b0;
      end
`ifdef ASCON_LOADER_MASK_EN
      if (ld || st) begin
         v.nonce[4:1] = m_lfsr[3:0];
         v.pt[4:1]    = m_lfsr[7:4];
         v.ad[4:1]    = m_lfsr[11:8];
         v.key[4:1]   = m_lfsr[15:12];
         v.r64        = m_lfsr[29:16];
         v.rpt        = m_lfsr[32:30];
         v.r128       = m_lfsr[35:33];
      end
`endif
      v.es   = st;
      v.busy = m_act;
      v.done = m_done;
      return v;
   endfunction

   // drive one cycle of control inputs and queue the expected result of the edge
   task automatic cycle(input bit st, input bit ab, input bit rdy);
      exp_t e;
      start_i = st; abort_i = ab; enc_ready_i = rdy;
      model_step(st, ab, rdy);
      e.cyc = cyc + 1;
      e.v   = model_out();
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic mid_reset();
      #1 rst = 1'b0;
      exp_q.delete();
      #1 compare("async_reset", act_v, '0);
      model_reset();
      @(posedge clk);
      #1 compare("reset_hold", act_v, '0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [K-1:0] k, input logic [127:0] n,
                          input logic [L-1:0] a, input logic [Y-1:0] p,
                          input int abort_at, input int rst_at, input int rdy_dly,
                          input int noise_at, input bit hold, input bit chk);
      logic [127:0] r;
      key_i = k; nonce_i = n; ad_i = a; pt_i = p;
      cycle(1, 0, 0);
      // scramble inputs so only the snapshot can produce correct bits
      key_i = rnd128(); nonce_i = rnd128();
      r = rnd128(); ad_i = r[L-1:0]; pt_i = r[Y-1:0];
      for (int c = 0; c < MAX + START_CYC; c++) begin
         if (chk && c == 0)
            compare("first_bits", outv_t'({key_o[0], nonce_o[0], ad_o[0], pt_o[0]}), outv_t'(4'b0000));
         if (chk && c == 1)
            compare("second_bits", outv_t'({key_o[0], nonce_o[0], ad_o[0], pt_o[0]}), outv_t'(4'b1011));
         if (c == abort_at) begin
            cycle(hold, 1, 0);
            return;
         end
         if (c == rst_at) begin
            mid_reset();
            return;
         end
         cycle(hold, 0, c == noise_at);
      end
      for (int w = 0; w < rdy_dly; w++) cycle(hold, 0, 0);
      cycle(hold, 0, 1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            compare("outputs", act_v, mon_e.v);
         end
      end
   end

   localparam logic [K-1:0]   B_KEY = 128'h5362006eff0b33bc8bb9950abdb242fc;
   localparam logic [127:0]   B_NON = 128'h1ccfafbc6dc738283ca9fe21ce0fccaa;
   localparam logic [L-1:0]   B_AD  = 40'h4153434f4e;
   localparam logic [Y-1:0]   B_PT  = 96'h48656c6c6f20576f726c6421;

   initial begin
      logic [127:0] r1, r2;
      int ab_at;
      model_reset();
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 compare("reset_state", act_v, '0);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;

      // basic load, ready 10 cycles into WAIT
      run_txn(B_KEY, B_NON, B_AD, B_PT, -1, -1, 10, -1, 0, 1);
      repeat (3) cycle(0, 0, 0);

      // start held high, ready pulsed during LOAD
      r1 = rnd128(); r2 = rnd128();
      run_txn(r1, r2, r1[L-1:0], r2[Y-1:0], -1, -1, 4, 20, 1, 0);
      cycle(1, 0, 0);   // done cycle: start dropped
      cycle(1, 0, 0);   // next idle cycle: accepted
      repeat (5) cycle(0, 0, 0);
      cycle(0, 1, 0);   // abort
      cycle(1, 1, 0);   // abort beats start in IDLE
      repeat (2) cycle(0, 0, 0);

      // abort at c=50 then a fresh full load
      r1 = rnd128(); r2 = rnd128();
      run_txn(r1, r2, r2[L-1:0], r1[Y-1:0], 50, -1, 0, -1, 0, 0);
      repeat (2) cycle(0, 0, 0);
      r1 = rnd128(); r2 = rnd128();
      run_txn(r2, r1, r1[L-1:0], r1[Y-1:0], -1, -1, 2, -1, 0, 0);
      repeat (2) cycle(0, 0, 0);

      // reset at c=70, then basic load again from a reseeded LFSR
      run_txn(B_KEY, B_NON, B_AD, B_PT, -1, 70, 0, -1, 0, 0);
      repeat (2) cycle(0, 0, 0);
      run_txn(B_KEY, B_NON, B_AD, B_PT, -1, -1, 10, -1, 0, 1);
      repeat (2) cycle(0, 0, 0);

      // randomized transactions
      for (int t = 0; t < 4; t++) begin
         r1 = rnd128(); r2 = rnd128();
         ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX + START_CYC - 1)) : -1;
         run_txn(r1, r2, r2[L-1:0], r1[Y-1:0], ab_at, -1, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, MAX - 1)), 0, 0);
         repeat (int'($urandom_range(1, 3))) cycle(0, 0, 0);
      end

      repeat (2) cycle(0, 0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
